smc_static_bus_master: RTL and testbench

// - Avalon-MM slave on q_clock. Acts as a master on an external asynchronous static-memory bus
//   (SAM9 SMC style: CSN/BEN/RDN/WRN/ADDR/DATA/WAITN). It is the FPGA-initiated counterpart of the host bridge.
// - Turns each Avalon read/write into one programmable setup/pulse/hold bus cycle.
// - Lets Qsys masters reach external SRAM or peripherals. One transaction outstanding at a time.

---
 rtl/smc_pkg.sv | 24 ++
 rtl/smc_waitn_sync.sv | 44 ++++
 rtl/smc_static_bus_master.sv | 143 ++++++++++++++
 tb/tb_smc_static_bus_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// rtl/smc_pkg.sv - shared types, timing defaults and chip-select decode for the static bus master
package smc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } smc_state_t;

   localparam int          DEF_SETUP_CYC   = 2;
   localparam int          DEF_PULSE_CYC   = 4;
   localparam int          DEF_HOLD_CYC    = 2;
   localparam int          DEF_TIMEOUT_CYC = 255;
   localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

   // Active-low one-hot-zero chip select for a 2-bit chip index
   function automatic logic [3:0] cs_decode(input logic [1:0] idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/smc_waitn_sync.sv
// rtl/smc_waitn_sync.sv - WAITN synchroniser and saturating strobe-extension timeout counter
module smc_waitn_sync
   import smc_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic q_clock,
   input  logic q_reset,
   input  logic ext_waitn,
   input  logic run,
   output logic waitn_s,
   output logic timeout_hit
);

   localparam logic [7:0] EXT_LAST = 8'(TIMEOUT_CYC - 1);

   logic       waitn_meta;
   logic [7:0] ext_cnt;

   // Two-flop synchroniser; idles at "not waiting" so a fresh cycle never stalls spuriously
   always_ff @(posedge q_clock or posedge q_reset) begin
      if (q_reset) begin
         waitn_meta <= 1'b1;
         waitn_s    <= 1'b1;
      end else begin
         waitn_meta <= ext_waitn;
         waitn_s    <= waitn_meta;
      end
   end

   // Counts extension cycles while the master is stalled by WAITN; cleared otherwise, saturates at 255
   always_ff @(posedge q_clock or posedge q_reset) begin
      if (q_reset) begin
         ext_cnt <= 8'd0;
      end else if (!run) begin
         ext_cnt <= 8'd0;
      end else if (ext_cnt != 8'hFF) begin
         ext_cnt <= ext_cnt + 8'd1;
      end
   end

   assign timeout_hit = run && (ext_cnt == EXT_LAST);

endmodule

// File: rtl/smc_static_bus_master.sv
// rtl/smc_static_bus_master.sv - Avalon-MM slave driving one setup/pulse/hold static-memory bus cycle per command
module smc_static_bus_master
   import smc_pkg::*;
#(
   parameter int          SETUP_CYC   = DEF_SETUP_CYC,
   parameter int          PULSE_CYC   = DEF_PULSE_CYC,
   parameter int          HOLD_CYC    = DEF_HOLD_CYC,
   parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
   input  logic        q_clock,
   input  logic        q_reset,
   input  logic [23:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic [21:0] ext_addr,
   output logic [31:0] ext_data_o,
   output logic        ext_data_oe,
   input  logic [31:0] ext_data_i,
   output logic [3:0]  ext_csn,
   output logic [3:0]  ext_ben,
   output logic        ext_rdn,
   output logic        ext_wrn,
   input  logic        ext_waitn,
   input  logic        timeout_clr,
   output logic        irq_timeout
);

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   smc_state_t state;
   logic [3:0] cnt;
   logic       is_read;
   logic       waitn_s;
   logic       timeout_hit;
   logic       ext_run;

   // Extension phase: minimum pulse already elapsed but the device still holds WAITN low
   assign ext_run = (state == ST_PULSE) && (cnt == 4'd0) && !waitn_s;

   smc_waitn_sync #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_waitn_sync (
      .q_clock     (q_clock),
      .q_reset     (q_reset),
      .ext_waitn   (ext_waitn),
      .run         (ext_run),
      .waitn_s     (waitn_s),
      .timeout_hit (timeout_hit)
   );

   // Bus-cycle FSM with every bus and Avalon output registered
   always_ff @(posedge q_clock or posedge q_reset) begin
      if (q_reset) begin
         state             <= ST_IDLE;
         cnt               <= 4'd0;
         is_read           <= 1'b0;
         ext_csn           <= 4'hF;
         ext_ben           <= 4'hF;
         ext_rdn           <= 1'b1;
         ext_wrn           <= 1'b1;
         ext_data_oe       <= 1'b0;
         ext_addr          <= 22'd0;
         ext_data_o        <= 32'd0;
         avs_readdata      <= 32'd0;
         avs_readdatavalid <= 1'b0;
         avs_waitrequest   <= 1'b1;
         irq_timeout       <= 1'b0;
      end else begin
         avs_readdatavalid <= 1'b0;
         // Setting the flag wins over a simultaneous clear so no abort is ever lost
         if (timeout_hit) begin
            irq_timeout <= 1'b1;
         end else if (timeout_clr) begin
            irq_timeout <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (avs_read || avs_write) begin
                  // A simultaneous read and write keeps the read only
                  is_read         <= avs_read;
                  ext_csn         <= cs_decode(avs_address[23:22]);
                  ext_addr        <= avs_address[21:0];
                  ext_ben         <= ~avs_byteenable;
                  ext_data_oe     <= !avs_read;
                  if (!avs_read) begin
                     ext_data_o <= avs_writedata;
                  end
                  avs_waitrequest <= 1'b1;
                  cnt             <= SETUP_LD;
                  state           <= ST_SETUP;
               end else begin
                  avs_waitrequest <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ext_rdn <= !is_read;
                  ext_wrn <= is_read;
                  cnt     <= PULSE_LD;
                  state   <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (waitn_s || timeout_hit) begin
                  ext_rdn <= 1'b1;
                  ext_wrn <= 1'b1;
                  if (is_read) begin
                     avs_readdata      <= waitn_s ? ext_data_i : ERR_DATA;
                     avs_readdatavalid <= 1'b1;
                  end
                  cnt   <= HOLD_LD;
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ext_csn         <= 4'hF;
                  ext_ben         <= 4'hF;
                  ext_data_oe     <= 1'b0;
                  avs_waitrequest <= 1'b0;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_smc_static_bus_master.sv
// tb/tb_smc_static_bus_master.sv - scoreboard bench for the static bus master
module tb_smc_static_bus_master;

   logic        q_clock = 1'b0;
   logic        q_reset = 1'b1;
   logic [23:0] avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [3:0]  avs_byteenable = '0;
   logic [31:0] ext_data_i = '0;
   logic        timeout_clr = 1'b0;
   logic        waitn_a = 1'b1;
   logic        waitn_b = 1'b1;

   logic [31:0] a_readdata, b_readdata, a_do, b_do;
   logic        a_rdv, b_rdv, a_wreq, b_wreq, a_oe, b_oe;
   logic [21:0] a_addr, b_addr;
   logic [3:0]  a_csn, b_csn, a_ben, b_ben;
   logic        a_rdn, b_rdn, a_wrn, b_wrn, a_irq, b_irq;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [31:0] qa[$];
   int          qa_lat[$];
   logic [31:0] qb[$];
   logic [31:0] exp_d;
   int          exp_l;
   int rdn_run = 0, rdn_last = 0, wrn_run = 0, wrn_last = 0, oe_run = 0, oe_last = 0;
   int wr_strobes = 0;
   int wr0 = 0;
   int n_idle = 0;
   logic overlap = 1'b0;

   // A: default timing; B: short timeout, fed its own WAITN
   smc_static_bus_master u_dut_a (
      .q_clock(q_clock), .q_reset(q_reset), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(a_readdata), .avs_readdatavalid(a_rdv), .avs_waitrequest(a_wreq),
      .ext_addr(a_addr), .ext_data_o(a_do), .ext_data_oe(a_oe), .ext_data_i(ext_data_i),
      .ext_csn(a_csn), .ext_ben(a_ben), .ext_rdn(a_rdn), .ext_wrn(a_wrn), .ext_waitn(waitn_a),
      .timeout_clr(timeout_clr), .irq_timeout(a_irq)
   );

   smc_static_bus_master #(.TIMEOUT_CYC(8)) u_dut_b (
      .q_clock(q_clock), .q_reset(q_reset), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(b_readdata), .avs_readdatavalid(b_rdv), .avs_waitrequest(b_wreq),
      .ext_addr(b_addr), .ext_data_o(b_do), .ext_data_oe(b_oe), .ext_data_i(ext_data_i),
      .ext_csn(b_csn), .ext_ben(b_ben), .ext_rdn(b_rdn), .ext_wrn(b_wrn), .ext_waitn(waitn_b),
      .timeout_clr(timeout_clr), .irq_timeout(b_irq)
   );

   always #5 q_clock = ~q_clock;

   always @(posedge q_clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Returns at a negedge with both masters idle; n = negedges waited
   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(negedge q_clock);
         n++;
      end while ((a_wreq || b_wreq) && n < 400);
      if (n >= 400) check_val("idle_bound", 32'd0, 32'd1);
   endtask

   // Presents one command, returns at the negedge right after the accepting edge
   task automatic issue(input logic rd, input logic wr, input logic [23:0] adr,
                        input logic [31:0] wd, input logic [3:0] be);
      int n;
      wait_idle(n);
      avs_read = rd;
      avs_write = wr;
      avs_address = adr;
      avs_writedata = wd;
      avs_byteenable = be;
      @(posedge q_clock);
      @(negedge q_clock);
      acc_cyc = cyc;
      avs_read = 1'b0;
      avs_write = 1'b0;
   endtask

   // Scoreboard and strobe-width monitor for instance A; scoreboard for B
   always @(negedge q_clock) begin
      if (q_reset) begin
         rdn_run = 0;
         wrn_run = 0;
         oe_run = 0;
      end else begin
         if (!a_rdn && !a_wrn) overlap = 1'b1;
         if (!a_rdn) rdn_run++;
         else if (rdn_run != 0) begin rdn_last = rdn_run; rdn_run = 0; end
         if (!a_wrn) begin
            if (wrn_run == 0) wr_strobes++;
            wrn_run++;
         end else if (wrn_run != 0) begin wrn_last = wrn_run; wrn_run = 0; end
         if (a_oe) oe_run++;
         else if (oe_run != 0) begin oe_last = oe_run; oe_run = 0; end
         if (a_rdv) begin
            if (qa.size() == 0) check_val("a_rdv_unexpected", 32'd1, 32'd0);
            else begin
               exp_d = qa.pop_front();
               exp_l = qa_lat.pop_front();
               check_val("a_rdata", a_readdata, exp_d);
               check_val("a_latency", 32'(cyc - acc_cyc + 1), 32'(exp_l));
            end
         end
         if (b_rdv) begin
            if (qb.size() == 0) check_val("b_rdv_unexpected", 32'd1, 32'd0);
            else check_val("b_rdata", b_readdata, qb.pop_front());
         end
      end
   end

   initial begin
      int n;
      // Reset values
      @(negedge q_clock);
      check_val("rst_csn", 32'(a_csn), 32'hF);
      check_val("rst_ben", 32'(a_ben), 32'hF);
      check_val("rst_strobes", 32'({a_rdn, a_wrn, a_oe}), 32'b110);
      check_val("rst_waitreq", 32'(a_wreq), 32'd1);
      check_val("rst_rdv_irq", 32'({a_rdv, a_irq}), 32'd0);
      @(negedge q_clock);
      q_reset = 1'b0;

      // Plain read, chip index 1
      ext_data_i = 32'h1234_5678;
      qa.push_back(32'h1234_5678); qa_lat.push_back(7);
      qb.push_back(32'h1234_5678);
      issue(1'b1, 1'b0, 24'h40_0010, 32'h0, 4'hF);
      check_val("rd_setup_csn", 32'(a_csn), 32'hD);
      check_val("rd_setup_addr", 32'(a_addr), 32'h10);
      @(negedge q_clock);
      check_val("rd_setup2_rdn", 32'({a_rdn, a_oe}), 32'b10);
      @(negedge q_clock);
      check_val("rd_pulse_rdn", 32'(a_rdn), 32'd0);
      wait_idle(n);
      @(negedge q_clock);
      check_val("rd_rdn_width", 32'(rdn_last), 32'd4);

      // Write, chip index 3, partial byte enables
      issue(1'b0, 1'b1, 24'hC0_0123, 32'hA5A5_0F0F, 4'b0011);
      check_val("wr_csn", 32'(a_csn), 32'h7);
      check_val("wr_ben", 32'(a_ben), 32'hC);
      check_val("wr_data", a_do, 32'hA5A5_0F0F);
      wait_idle(n);
      check_val("wr_turnaround", 32'(n + 1), 32'd9);
      @(negedge q_clock);
      check_val("wr_wrn_width", 32'(wrn_last), 32'd4);
      check_val("wr_oe_width", 32'(oe_last), 32'd8);

      // Read stretched by WAITN on A: device drops WAITN just after the strobe and releases it 13 cycles later
      ext_data_i = 32'hCAFE_0042;
      qa.push_back(32'hCAFE_0042); qa_lat.push_back(2 + 16 + 1);
      qb.push_back(32'hCAFE_0042);
      issue(1'b1, 1'b0, 24'h00_0200, 32'h0, 4'hF);
      n = 0;
      while (a_rdn && n < 20) begin @(negedge q_clock); n++; end
      waitn_a = 1'b0;
      repeat (13) @(negedge q_clock);
      waitn_a = 1'b1;
      wait_idle(n);
      @(negedge q_clock);
      check_val("wait_rdn_width", 32'(rdn_last), 32'd16);
      check_val("wait_no_irq", 32'(a_irq), 32'd0);

      // WAITN stuck low on B: abort with error data and sticky irq
      ext_data_i = 32'h0BAD_F00D;
      waitn_b = 1'b0;
      qa.push_back(32'h0BAD_F00D); qa_lat.push_back(7);
      qb.push_back(32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 24'h80_0004, 32'h0, 4'hF);
      wait_idle(n);
      waitn_b = 1'b1;
      repeat (3) @(negedge q_clock);
      check_val("to_irq_set", 32'(b_irq), 32'd1);
      check_val("to_irq_a_clear", 32'(a_irq), 32'd0);
      timeout_clr = 1'b1;
      @(negedge q_clock);
      timeout_clr = 1'b0;
      check_val("to_irq_cleared", 32'(b_irq), 32'd0);

      // Asynchronous reset in the middle of a write strobe
      issue(1'b0, 1'b1, 24'h40_0008, 32'h5555_AAAA, 4'hF);
      n = 0;
      while (a_wrn && n < 20) begin @(negedge q_clock); n++; end
      #2 q_reset = 1'b1;
      #1;
      check_val("arst_wrn", 32'(a_wrn), 32'd1);
      check_val("arst_csn", 32'(a_csn), 32'hF);
      check_val("arst_oe", 32'(a_oe), 32'd0);
      @(posedge q_clock);
      @(negedge q_clock);
      q_reset = 1'b0;
      ext_data_i = 32'h7777_1111;
      qa.push_back(32'h7777_1111); qa_lat.push_back(7);
      qb.push_back(32'h7777_1111);
      issue(1'b1, 1'b0, 24'h00_0001, 32'h0, 4'hF);
      wait_idle(n);

      // Read and write requested together, then a write straight after
      $display("note: master drives read and write together; the write must be dropped");
      ext_data_i = 32'h3C3C_C3C3;
      wr0 = wr_strobes;
      qa.push_back(32'h3C3C_C3C3); qa_lat.push_back(7);
      qb.push_back(32'h3C3C_C3C3);
      issue(1'b1, 1'b1, 24'hC0_0020, 32'h1111_2222, 4'hF);
      check_val("both_oe_off", 32'(a_oe), 32'd0);
      issue(1'b0, 1'b1, 24'h40_0030, 32'h9999_0000, 4'hF);
      check_val("b2b_read_done_first", 32'(wr_strobes - wr0), 32'd0);
      wait_idle(n);
      @(negedge q_clock);
      check_val("b2b_write_strobes", 32'(wr_strobes - wr0), 32'd1);

      check_val("no_rd_wr_overlap", 32'(overlap), 32'd0);
      check_val("qa_drained", 32'(qa.size()), 32'd0);
      check_val("qb_drained", 32'(qb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
